// File: rtl/stopwatch_ctrl_if.sv
// Button and control bundle between the board/bench side and the stopwatch sequencer.
// STRTSTOP/LAPCLR are raw active-low buttons; the rest drive the digit counter chain.
interface stopwatch_ctrl_if;
    logic       STRTSTOP;
    logic       LAPCLR;
    logic       CNT_EN;
    logic       CNT_CLR;
    logic       TICK;
    logic       DISP_HOLD;
    logic [1:0] STATE;

    modport master (
        output STRTSTOP, LAPCLR,
        input  CNT_EN, CNT_CLR, TICK, DISP_HOLD, STATE
    );

    modport slave (
        input  STRTSTOP, LAPCLR,
        output CNT_EN, CNT_CLR, TICK, DISP_HOLD, STATE
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button conditioning (sync, debounce, press detect), the
// start/stop/lap/clear FSM and the tenths tick prescaler.
module stopwatch_ctrl #(
    parameter int TICK_DIV  = 10,
    parameter int DB_CYCLES = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    stopwatch_ctrl_if.slave  sw
);
    localparam int PS_W = $clog2(TICK_DIV);
    localparam int DB_W = $clog2(DB_CYCLES);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'b00,
        ST_RUN   = 2'b01,
        ST_LAP   = 2'b10,
        ST_STOP  = 2'b11
    } state_t;

    logic [1:0] btn_raw;
    logic [1:0] press;

    assign btn_raw = {sw.LAPCLR, sw.STRTSTOP};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic            meta_q, sync_q, deb_q, press_q;
            logic            meta_d, sync_d, deb_d, press_d;
            logic [DB_W-1:0] cnt_q, cnt_d;

            // The level is accepted on the edge where the count would reach DB_CYCLES.
            always_comb begin
                meta_d = btn_raw[gi];
                sync_d = meta_q;
                deb_d  = deb_q;
                cnt_d  = '0;
                if (sync_q != deb_q) begin
                    if (cnt_q == DB_LAST) begin
                        deb_d = sync_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                press_d = deb_q & ~deb_d;
            end

            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    meta_q  <= 1'b1;
                    sync_q  <= 1'b1;
                    deb_q   <= 1'b1;
                    cnt_q   <= '0;
                    press_q <= 1'b0;
                end else begin
                    meta_q  <= meta_d;
                    sync_q  <= sync_d;
                    deb_q   <= deb_d;
                    cnt_q   <= cnt_d;
                    press_q <= press_d;
                end
            end

            assign press[gi] = press_q;
        end
    endgenerate

    state_t          state_q, state_d;
    logic [PS_W-1:0] ps_q, ps_d;
    logic            tick_q, tick_d;
    logic            cnt_en_q, cnt_en_d;
    logic            cnt_clr_q, cnt_clr_d;
    logic            disp_hold_q, disp_hold_d;
    logic            start, lap, counting_q, counting_d;

    assign start = press[0];
    assign lap   = press[1];

    // Start has priority: a simultaneous lap press is simply dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (start) state_d = ST_RUN;
            ST_RUN:   if (start) state_d = ST_STOP; else if (lap) state_d = ST_LAP;
            ST_LAP:   if (start) state_d = ST_STOP; else if (lap) state_d = ST_RUN;
            ST_STOP:  if (start) state_d = ST_RUN;  else if (lap) state_d = ST_CLEAR;
            default:  state_d = ST_CLEAR;
        endcase
    end

    assign counting_q = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign counting_d = (state_d == ST_RUN) || (state_d == ST_LAP);

    // Tick is suppressed on the edge that leaves a counting state; STOPPED keeps the partial tenth.
    always_comb begin
        ps_d   = ps_q;
        tick_d = 1'b0;
        if (state_q == ST_CLEAR || state_d == ST_CLEAR) begin
            ps_d = '0;
        end else if (counting_q) begin
            if (ps_q == PS_LAST) begin
                ps_d   = '0;
                tick_d = counting_d;
            end else begin
                ps_d = ps_q + 1'b1;
            end
        end
        cnt_clr_d   = (state_d == ST_CLEAR);
        cnt_en_d    = counting_d;
        disp_hold_d = (state_d == ST_LAP);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_CLEAR;
            ps_q        <= '0;
            tick_q      <= 1'b0;
            cnt_en_q    <= 1'b0;
            cnt_clr_q   <= 1'b1;
            disp_hold_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ps_q        <= ps_d;
            tick_q      <= tick_d;
            cnt_en_q    <= cnt_en_d;
            cnt_clr_q   <= cnt_clr_d;
            disp_hold_q <= disp_hold_d;
        end
    end

    assign sw.STATE     = state_q;
    assign sw.TICK      = tick_q;
    assign sw.CNT_EN    = cnt_en_q;
    assign sw.CNT_CLR   = cnt_clr_q;
    assign sw.DISP_HOLD = disp_hold_q;
endmodule
